asg_sweep_gen: RTL and testbench
================================

Name: asg_sweep_gen

Overview:
Per-channel frequency-sweep controller directly upstream of the ASG channel. Produces the phase-accumulator step word fed to the channel's pointer-step input. Ramps that word linearly from a start step to a stop step, on a 1 us tick grid, with a programmable dwell per increment. One instance per ASG channel, all logic in the DAC clock domain.

Parameters:
RSZ, 14, buffer address width; step word width is RSZ+16.
TICK_DIV, 125, dac_clk_i cycles per sweep tick (1 us at 125 MHz).

Ports:
dac_clk_i  in  1  DAC clock
dac_rst_i  in  1  synchronous reset, active-high
sweep_start_i  in  1  start/restart pulse
sweep_stop_i  in  1  abort pulse
set_start_step_i  in  RSZ+16  first step word
set_stop_step_i  in  RSZ+16  final step word
set_inc_i  in  RSZ+16  step-word increment magnitude per dwell interval
set_dwell_i  in  16  ticks per step value; 0 treated as 1
set_mode_i  in  2  0 single, 1 repeat (sawtooth), 2 up-down (ping-pong), 3 same as 0
step_o  out  RSZ+16  step word to ASG channel
step_upd_o  out  1  one-cycle pulse, step_o changed this cycle
busy_o  out  1  sweep active
done_o  out  1  one-cycle pulse, single sweep finished
dir_o  out  1  current direction, 1 = increasing

Behaviour:
- Reset: state IDLE; step_o=0, step_upd_o=0, busy_o=0, done_o=0, dir_o=1, tick prescaler and dwell counter 0.
- Config latch: all set_* sampled on the sweep_start_i cycle. Later changes are ignored until the next start.
- Direction: dir = (stop >= start) on load. Target = stop. In up-down mode the start and stop roles swap at each endpoint.
- States:
  - IDLE -> LOAD on sweep_start_i.
  - LOAD (1 cycle): step_o<=start, step_upd_o=1, busy_o=1, prescaler and dwell counter cleared -> DWELL.
  - DWELL: prescaler counts 0..TICK_DIV-1. On wrap, dwell counter increments. When dwell counter reaches max(dwell,1) -> STEP.
  - STEP (1 cycle):
    - If step_o != target: next = step_o +/- inc, computed in RSZ+17 bits; clamp to target if it passes target or overflows/underflows. step_o<=next, step_upd_o=1 -> DWELL.
    - If step_o == target, mode 0/3: done_o=1, busy_o<=0 -> IDLE.
    - If step_o == target, mode 1: step_o<=start, step_upd_o=1 -> DWELL.
    - If step_o == target, mode 2: swap endpoints, dir_o toggles, next step computed toward the new target in this same STEP cycle -> DWELL.
- Latency: start pulse in cycle N -> step_o=start and step_upd_o in cycle N+2 (LOAD registered). Each step value is held exactly max(dwell,1)*TICK_DIV+1 cycles; the +1 is the STEP cycle.
- Endpoint value: held for its full dwell before done/reload/reverse.
- inc==0: step_o stays at start. Mode 0 finishes after one dwell, same as start==stop. Modes 1/2 hold start until stopped.
- start==stop: single value. Mode 0 asserts done after one dwell. Modes 1/2 keep re-emitting step_upd_o each dwell with an unchanged value.
- sweep_stop_i: -> IDLE next cycle, busy_o=0, step_o holds its current value, no done_o.
- Simultaneous stop and start: stop wins. Start while busy: restart via LOAD with freshly latched config.
- Reset mid-sweep: all outputs return to reset values on the next edge.

Optional Feature:
ASG_SWEEP_CNT_EN:
- Defined: adds input set_nsweep_i [16]. In modes 1/2, each endpoint event decrements a counter loaded on start. When the counter hits 0 the block behaves as mode 0 at that endpoint (done_o, IDLE). set_nsweep_i=0 means unlimited.
- Undefined: port absent; modes 1/2 run until stop or reset.

Test Plan:
- Single up, TICK_DIV=4: start=100, stop=130, inc=10, dwell=2, mode 0 -> step_o sequence 100,110,120,130, each held 9 cycles. done_o pulses once after 130's dwell; busy_o falls that cycle.
- Clamp and down sweep: start=1000, stop=975, inc=10, mode 0 -> 1000,990,980,975; dir_o=0 throughout.
- Up-down: start=0, stop=20, inc=10, mode 2 -> 0,10,20,10,0,10,... with dir_o toggling at 20 and 0; step_o=20 and step_o=0 each held one full dwell.
- Overflow: start=2^30-16, stop=2^30-1, inc=2^29, mode 0 -> second value clamps to 2^30-1 with no wrap to a small value.
- Abort/race: stop and start asserted together mid-sweep -> IDLE, busy_o=0, step_o frozen. A later start alone -> step_o=start two cycles after the start pulse.
- With ASG_SWEEP_CNT_EN, mode 1, nsweep=2, start=0, stop=10, inc=10 -> 0,10,0,10, then done_o; exactly two endpoint events counted.

Source files
------------

// File: rtl/asg_sweep_gen.sv
`default_nettype none
// ------------------------------------------------------------------------------------------
// asg_sweep_gen: linear step-word sweep for one ASG channel (single / sawtooth / ping-pong).
// Optional ASG_SWEEP_CNT_EN limits repeat/ping-pong runs to set_nsweep_i endpoints. Rev 1.0
// ------------------------------------------------------------------------------------------
module asg_sweep_gen #(
  parameter int RSZ      = 14,
  parameter int TICK_DIV = 125
) (
  input  logic              dac_clk_i,
  input  logic              dac_rst_i,
  input  logic              sweep_start_i,
  input  logic              sweep_stop_i,
  input  logic [RSZ+15:0]   set_start_step_i,
  input  logic [RSZ+15:0]   set_stop_step_i,
  input  logic [RSZ+15:0]   set_inc_i,
  input  logic [15:0]       set_dwell_i,
  input  logic [1:0]        set_mode_i,
`ifdef ASG_SWEEP_CNT_EN
  input  logic [15:0]       set_nsweep_i,
`endif
  output logic [RSZ+15:0]   step_o,
  output logic              step_upd_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              dir_o
);

  localparam int W  = RSZ + 16;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST   = PW'(TICK_DIV - 1);
  localparam logic [1:0]    M_REPEAT   = 2'd1;
  localparam logic [1:0]    M_PINGPONG = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DWELL = 2'd2,
    S_STEP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    step_q, step_d;
  logic            upd_q, upd_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            dir_q, dir_d;
  logic [PW-1:0]   pre_q, pre_d;
  logic [15:0]     dwell_q, dwell_d;
  logic [15:0]     dmax_q, dmax_d;
  logic [W-1:0]    from_q, from_d;
  logic [W-1:0]    tgt_q, tgt_d;
  logic [W-1:0]    inc_q, inc_d;
  logic [1:0]      mode_q, mode_d;

  logic            w_at_end;
  logic            w_repeat;
  logic            w_last;

`ifdef ASG_SWEEP_CNT_EN
  logic [15:0]     cnt_q, cnt_d;
  // cnt_q == 0 means unlimited; the endpoint that would take it from 1 to 0 ends the run.
  assign w_last = (cnt_q == 16'd1);
`else
  assign w_last = 1'b0;
`endif

  // One increment toward tgt in W+1 bits; any pass beyond tgt or wrap clamps to tgt.
  function automatic logic [W-1:0] calc_next(input logic [W-1:0] cur,
                                             input logic [W-1:0] inc,
                                             input logic [W-1:0] tgt,
                                             input logic         up);
    logic [W:0] s;
    if (up) begin
      s = {1'b0, cur} + {1'b0, inc};
      calc_next = (s > {1'b0, tgt}) ? tgt : s[W-1:0];
    end else begin
      s = {1'b0, cur} - {1'b0, inc};
      calc_next = (s[W] || (s[W-1:0] < tgt)) ? tgt : s[W-1:0];
    end
  endfunction

  assign w_at_end = (step_q == tgt_q) || (inc_q == '0);
  assign w_repeat = (mode_q == M_REPEAT) || (mode_q == M_PINGPONG);

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    upd_d   = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dir_d   = dir_q;
    pre_d   = pre_q;
    dwell_d = dwell_q;
    dmax_d  = dmax_q;
    from_d  = from_q;
    tgt_d   = tgt_q;
    inc_d   = inc_q;
    mode_d  = mode_q;
`ifdef ASG_SWEEP_CNT_EN
    cnt_d   = cnt_q;
`endif

    if (sweep_stop_i) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
    end else if (sweep_start_i) begin
      state_d = S_LOAD;
      busy_d  = 1'b1;
      from_d  = set_start_step_i;
      tgt_d   = set_stop_step_i;
      inc_d   = set_inc_i;
      mode_d  = set_mode_i;
      dmax_d  = (set_dwell_i == 16'd0) ? 16'd1 : set_dwell_i;
      dir_d   = (set_stop_step_i >= set_start_step_i);
`ifdef ASG_SWEEP_CNT_EN
      cnt_d   = set_nsweep_i;
`endif
    end else begin
      case (state_q)
        S_LOAD: begin
          step_d  = from_q;
          upd_d   = 1'b1;
          pre_d   = '0;
          dwell_d = '0;
          state_d = S_DWELL;
        end
        S_DWELL: begin
          if (pre_q == PRE_LAST) begin
            pre_d = '0;
            if (dwell_q + 16'd1 == dmax_q) begin
              dwell_d = '0;
              state_d = S_STEP;
            end else begin
              dwell_d = dwell_q + 16'd1;
            end
          end else begin
            pre_d = pre_q + PW'(1);
          end
        end
        S_STEP: begin
          state_d = S_DWELL;
          if (!w_at_end) begin
            step_d = calc_next(step_q, inc_q, tgt_q, dir_q);
            upd_d  = 1'b1;
          end else if (!w_repeat || w_last) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
`ifdef ASG_SWEEP_CNT_EN
            if (cnt_q != 16'd0) cnt_d = cnt_q - 16'd1;
`endif
            upd_d = 1'b1;
            if (mode_q == M_REPEAT) begin
              step_d = from_q;
            end else begin
              // Ping-pong: swap endpoints and take the first step back in this same cycle.
              from_d = tgt_q;
              tgt_d  = from_q;
              dir_d  = ~dir_q;
              step_d = calc_next(step_q, inc_q, from_q, ~dir_q);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge dac_clk_i) begin
    if (dac_rst_i) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      upd_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dir_q   <= 1'b1;
      pre_q   <= '0;
      dwell_q <= '0;
      dmax_q  <= 16'd1;
      from_q  <= '0;
      tgt_q   <= '0;
      inc_q   <= '0;
      mode_q  <= '0;
`ifdef ASG_SWEEP_CNT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      upd_q   <= upd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dir_q   <= dir_d;
      pre_q   <= pre_d;
      dwell_q <= dwell_d;
      dmax_q  <= dmax_d;
      from_q  <= from_d;
      tgt_q   <= tgt_d;
      inc_q   <= inc_d;
      mode_q  <= mode_d;
`ifdef ASG_SWEEP_CNT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign step_o     = step_q;
  assign step_upd_o = upd_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign dir_o      = dir_q;

endmodule

`default_nettype wire

// File: tb/tb_asg_sweep_gen.sv
`default_nettype none
// ------------------------------------------------------------------------------------------
// tb_asg_sweep_gen: directed and randomized sweeps against a sequence-list reference model.
// ------------------------------------------------------------------------------------------
module tb_asg_sweep_gen;

  localparam int RSZ = 14;
  localparam int W   = RSZ + 16;
  localparam int T   = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sweep_start = 1'b0;
  logic          sweep_stop  = 1'b0;
  logic [W-1:0]  set_start_step = '0;
  logic [W-1:0]  set_stop_step  = '0;
  logic [W-1:0]  set_inc        = '0;
  logic [15:0]   set_dwell      = '0;
  logic [1:0]    set_mode       = '0;
`ifdef ASG_SWEEP_CNT_EN
  logic [15:0]   nsweep         = '0;
`endif
  logic [W-1:0]  step;
  logic          step_upd;
  logic          busy;
  logic          done;
  logic          dir;

  int nassert = 0;
  int nfail   = 0;

  longint ev[$];
  bit     ed[$];

  asg_sweep_gen #(.RSZ(RSZ), .TICK_DIV(T)) dut (
    .dac_clk_i        (clk),
    .dac_rst_i        (rst),
    .sweep_start_i    (sweep_start),
    .sweep_stop_i     (sweep_stop),
    .set_start_step_i (set_start_step),
    .set_stop_step_i  (set_stop_step),
    .set_inc_i        (set_inc),
    .set_dwell_i      (set_dwell),
    .set_mode_i       (set_mode),
`ifdef ASG_SWEEP_CNT_EN
    .set_nsweep_i     (nsweep),
`endif
    .step_o           (step),
    .step_upd_o       (step_upd),
    .busy_o           (busy),
    .done_o           (done),
    .dir_o            (dir)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Values visited walking from a toward b in steps of inc, landing exactly on b.
  task automatic add_seg(input longint a, input longint b, input longint inc,
                         input bit skip_first, input bit d);
    longint v = a;
    if (!skip_first) begin ev.push_back(v); ed.push_back(d); end
    while (v != b && inc != 0 && ev.size() < 400) begin
      if (b >= a) v = (v + inc > b) ? b : v + inc;
      else        v = (v - inc < b) ? b : v - inc;
      ev.push_back(v);
      ed.push_back(d);
    end
  endtask

  task automatic build_model(input longint s, input longint e, input longint inc,
                             input int md, input int nsw, input int nchk,
                             output bit exp_done);
    longint a, b, tmp;
    bit d;
    int k;
    int lim;
    ev.delete();
    ed.delete();
    exp_done = 1'b0;
`ifdef ASG_SWEEP_CNT_EN
    lim = nsw;
`else
    lim = 0;
    if (nsw != 0) lim = 0;
`endif
    a = s; b = e; d = (e >= s); k = 0;
    if (md == 0 || md == 3) begin
      add_seg(s, e, inc, 1'b0, d);
      exp_done = (nchk >= ev.size());
    end else begin
      while (k < 200) begin
        add_seg(a, b, inc, (md == 2) && (k > 0), d);
        k++;
        if (lim != 0 && k == lim) begin exp_done = 1'b1; break; end
        if (ev.size() >= nchk) break;
        if (md == 2) begin tmp = a; a = b; b = tmp; d = ~d; end
      end
    end
  endtask

  task automatic run_sweep(input longint s, input longint e, input longint inc,
                           input int dw, input int md, input int nsw, input int nchk,
                           input bit race);
    bit exp_done;
    int n;
    int hold;
    longint frozen;
    build_model(s, e, inc, md, nsw, nchk, exp_done);
    hold = ((dw == 0) ? 1 : dw) * T;
    n = exp_done ? ev.size() : ((nchk < ev.size()) ? nchk : ev.size());
    set_start_step = s[W-1:0];
    set_stop_step  = e[W-1:0];
    set_inc        = inc[W-1:0];
    set_dwell      = dw[15:0];
    set_mode       = md[1:0];
`ifdef ASG_SWEEP_CNT_EN
    nsweep         = nsw[15:0];
`endif
    sweep_start = 1'b1;
    @(negedge clk);
    sweep_start = 1'b0;
    // Config changes after the start pulse must have no effect.
    set_start_step = W'($urandom);
    set_stop_step  = W'($urandom);
    set_inc        = W'($urandom);
    set_dwell      = 16'($urandom_range(0, 7));
    set_mode       = 2'($urandom);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("step_first", step, ev[i]);
      check("upd_first", step_upd, 1);
      check("busy_run", busy, 1);
      check("dir", dir, ed[i]);
      check("done_early", done, 0);
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        check("step_hold", step, ev[i]);
        check("upd_hold", step_upd, 0);
        check("done_hold", done, 0);
      end
    end
    if (exp_done) begin
      @(negedge clk);
      check("done_pulse", done, 1);
      check("busy_end", busy, 0);
      check("upd_end", step_upd, 0);
      check("step_end", step, ev[n-1]);
      @(negedge clk);
      check("done_once", done, 0);
    end else begin
      frozen = ev[n-1];
      if (race) begin
        set_start_step = W'($urandom_range(0, 1000));
        sweep_start = 1'b1;
      end
      sweep_stop = 1'b1;
      @(negedge clk);
      sweep_stop  = 1'b0;
      sweep_start = 1'b0;
      for (int c = 0; c < 3; c++) begin
        check("busy_abort", busy, 0);
        check("step_frozen", step, frozen);
        check("upd_abort", step_upd, 0);
        check("done_abort", done, 0);
        @(negedge clk);
      end
    end
  endtask

  task automatic check_reset_vals();
    check("rst_step", step, 0);
    check("rst_upd", step_upd, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dir", dir, 1);
  endtask

  initial begin
    longint rs, re, ri;
    int rm, rd, rn, rc;
    bit rr;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_vals();
    @(negedge clk);

    run_sweep(100, 130, 10, 2, 0, 0, 1000, 1'b0);
    run_sweep(1000, 975, 10, 2, 0, 0, 1000, 1'b0);
    run_sweep(0, 20, 10, 1, 2, 0, 9, 1'b0);
    run_sweep(64'd1073741808, 64'd1073741823, 64'd536870912, 0, 0, 0, 1000, 1'b0);
    run_sweep(100, 300, 10, 1, 0, 0, 3, 1'b1);
    run_sweep(50, 70, 10, 1, 3, 0, 1000, 1'b0);
    run_sweep(40, 90, 0, 2, 0, 0, 1000, 1'b0);
    run_sweep(77, 77, 5, 1, 1, 0, 4, 1'b0);
    run_sweep(500, 470, 10, 1, 1, 0, 7, 1'b0);
`ifdef ASG_SWEEP_CNT_EN
    run_sweep(0, 10, 10, 1, 1, 2, 1000, 1'b0);
    run_sweep(0, 20, 10, 1, 2, 3, 1000, 1'b0);
`endif

    // Reset in the middle of a downward sweep.
    set_start_step = W'(600);
    set_stop_step  = W'(500);
    set_inc        = W'(10);
    set_dwell      = 16'd1;
    set_mode       = 2'd1;
    sweep_start = 1'b1;
    @(negedge clk);
    sweep_start = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_vals();
    @(negedge clk);

    for (int it = 0; it < 20; it++) begin
      rs = longint'($urandom_range(0, 200));
      re = longint'($urandom_range(0, 200));
      ri = ($urandom_range(0, 9) == 0) ? 0 : longint'($urandom_range(5, 60));
      rd = $urandom_range(0, 3);
      rm = $urandom_range(0, 3);
      rn = 0;
      rr = 1'($urandom);
      if (rm == 2 && (ri == 0 || rs == re)) begin
        ri = 7;
        re = rs + 33;
      end
      if (rm == 1 || rm == 2) begin
        rc = $urandom_range(4, 10);
`ifdef ASG_SWEEP_CNT_EN
        rn = $urandom_range(0, 3);
`endif
      end else begin
        rc = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 1000;
      end
      run_sweep(rs, re, ri, rd, rm, rn, rc, rr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

endmodule

`default_nettype wire
